// File: rtl/led_pkg.sv
// Shared constants for the LED PWM fader: full-scale duty value and the
// width of the fade-divider counter.
package led_pkg;

  // Full-scale duty (and last PWM counter value) for a given counter width.
  function automatic int pwm_max(input int bits);
    return (32'sd1 <<< bits) - 32'sd1;
  endfunction

  // Width of a counter spanning 0..div-1, never narrower than one bit.
  function automatic int fade_cnt_w(input int div);
    return (div <= 32'sd2) ? 32'sd1 : $clog2(div);
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: saturating duty register, PWM compare and the
// active-low output flop.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_step_due,
  input  logic                i_pattern,
  input  logic                i_enable,
  output logic                o_led,
  output logic                o_busy
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX  = PWM_BITS'(pwm_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] DUTY_ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1'b1);

  logic [PWM_BITS-1:0] r_duty;
  logic                r_led;
  logic                w_on;

  // Full-scale duty is forced on so the LED never blinks off when pwm_cnt hits MAX.
  assign w_on   = (r_duty == DUTY_MAX) || (i_pwm_cnt < r_duty);
  assign o_busy = i_pattern ? (r_duty != DUTY_MAX) : (r_duty != DUTY_ZERO);
  assign o_led  = r_led;

  // Duty stepping toward the sampled target and registered LED drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_duty <= DUTY_ZERO;
      r_led  <= 1'b1;
    end else begin
      if (i_step_due) begin
        if (i_pattern && (r_duty != DUTY_MAX)) begin
          r_duty <= r_duty + DUTY_ONE;
        end else if (!i_pattern && (r_duty != DUTY_ZERO)) begin
          r_duty <= r_duty - DUTY_ONE;
        end else begin
          r_duty <= r_duty;
        end
      end
      r_led <= ~(w_on & i_enable);
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// Multi-channel LED fader: shared PWM timebase and fade divider driving
// N_LEDS channels that ramp their duty toward the requested on/off pattern.
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10000000,
  parameter int N_LEDS      = 8,
  parameter int PWM_BITS    = 8,
  parameter int FADE_DIV    = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_LEDS-1:0] pattern_i,
  input  logic              enable_i,
  output logic [N_LEDS-1:0] leds,
  output logic              busy_o,
  output logic              period_tick_o
);

  localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'(pwm_max(PWM_BITS));
  localparam int                  FCW       = fade_cnt_w(FADE_DIV);
  localparam logic [FCW-1:0]      FADE_LAST = FCW'(FADE_DIV - 1);

  if ((PWM_BITS < 2) || (PWM_BITS > 12) || (FADE_DIV < 1) || (CLK_FREQ_HZ < 1)) begin : g_bad_param
    $error("led_pwm_fader: illegal parameter value");
  end

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [FCW-1:0]      r_fade_cnt;
  logic                r_tick;
  logic                r_busy;
  logic                w_period_end;
  logic                w_step_due;
  logic [N_LEDS-1:0]   w_busy;

  assign w_period_end  = (r_pwm_cnt == PWM_LAST);
  assign w_step_due    = w_period_end && (r_fade_cnt == FADE_LAST);
  assign period_tick_o = r_tick;
  assign busy_o        = r_busy;

  // Free-running PWM counter, fade divider, period strobe and busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm_cnt  <= {PWM_BITS{1'b0}};
      r_fade_cnt <= {FCW{1'b0}};
      r_tick     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1'b1);
      if (w_step_due) begin
        r_fade_cnt <= {FCW{1'b0}};
      end else if (w_period_end) begin
        r_fade_cnt <= r_fade_cnt + FCW'(1'b1);
      end else begin
        r_fade_cnt <= r_fade_cnt;
      end
      r_tick <= w_period_end;
      r_busy <= |w_busy;
    end
  end

  for (genvar g = 0; g < N_LEDS; g++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_pwm_cnt  (r_pwm_cnt),
      .i_step_due (w_step_due),
      .i_pattern  (pattern_i[g]),
      .i_enable   (enable_i),
      .o_led      (leds[g]),
      .o_busy     (w_busy[g])
    );
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench: two faders (FADE_DIV 1 and 3) against a time-based
// model of duty steps, PWM compare and busy/tick outputs.
module tb_led_pwm_fader;

  localparam int NL   = 4;
  localparam int MAXV = 15;
  localparam int PER  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [NL-1:0] pattern;
  logic [NL-1:0] leds1, leds3;
  logic          busy1, busy3, tick1, tick3;

  always #5 clk = ~clk;

  led_pwm_fader #(.CLK_FREQ_HZ(10000000), .N_LEDS(NL), .PWM_BITS(4), .FADE_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pattern_i(pattern), .enable_i(enable),
    .leds(leds1), .busy_o(busy1), .period_tick_o(tick1));

  led_pwm_fader #(.CLK_FREQ_HZ(10000000), .N_LEDS(NL), .PWM_BITS(4), .FADE_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .pattern_i(pattern), .enable_i(enable),
    .leds(leds3), .busy_o(busy3), .period_tick_o(tick3));

  int n_checks = 0;
  int n_errors = 0;

  // Model: m_t is the number of cycles since reset release; duty per DUT/LED.
  int            m_t;
  int            m_duty [2][NL];
  int            fdiv   [2] = '{1, 3};
  logic [NL-1:0] e_leds [2];
  logic          e_busy [2];
  logic          e_tick;

  // Computes what the DUTs show after the coming edge, advances the model, clocks.
  task automatic tick();
    int   pwm;
    logic on;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        e_leds[d] = '1;
        e_busy[d] = 1'b0;
        for (int i = 0; i < NL; i++) m_duty[d][i] = 0;
      end
      e_tick = 1'b0;
      m_t    = 0;
    end else begin
      pwm    = m_t % PER;
      e_tick = (pwm == PER - 1);
      for (int d = 0; d < 2; d++) begin
        e_busy[d] = 1'b0;
        for (int i = 0; i < NL; i++) begin
          on = (m_duty[d][i] == MAXV) || (pwm < m_duty[d][i]);
          e_leds[d][i] = !(on && enable);
          if (pattern[i] ? (m_duty[d][i] < MAXV) : (m_duty[d][i] > 0)) e_busy[d] = 1'b1;
        end
        if ((pwm == PER - 1) && ((m_t / PER) % fdiv[d] == fdiv[d] - 1)) begin
          for (int i = 0; i < NL; i++) begin
            if (pattern[i] && m_duty[d][i] < MAXV) m_duty[d][i]++;
            else if (!pattern[i] && m_duty[d][i] > 0) m_duty[d][i]--;
          end
        end
      end
      m_t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [NL-1:0] pat);
    pattern = pat;
    enable  = 1'b1;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; pattern = 4'b1111;
    repeat (4) begin
      tick();
      n_checks++;
      if ({leds1, busy1, tick1} !== 6'b1111_0_0) begin
        n_errors++;
        $display("FAIL reset_hold got leds=%b busy=%b tick=%b exp 1111/0/0", leds1, busy1, tick1);
      end
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy1 !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_busy got %b exp 1", busy1);
    end
  endtask

  task automatic test_ramp_up();
    do_reset(4'b0001);
    repeat (15 * PER) begin
      tick();
      n_checks++;
      if ({leds1, busy1, tick1} !== {e_leds[0], e_busy[0], e_tick}) begin
        n_errors++;
        $display("FAIL ramp_model t=%0d got %b%b%b exp %b%b%b", m_t, leds1, busy1, tick1, e_leds[0], e_busy[0], e_tick);
      end
    end
    repeat (PER) begin
      tick();
      n_checks++;
      if ({leds1, busy1} !== 5'b1110_0) begin
        n_errors++;
        $display("FAIL ramp_full t=%0d got leds=%b busy=%b exp 1110/0", m_t, leds1, busy1);
      end
    end
  endtask

  task automatic test_pwm_duty4();
    int lit, ticks;
    do_reset(4'b0001);
    for (int k = 0; k < 200 && m_duty[0][0] != 4; k++) tick();
    n_checks++;
    if (m_duty[0][0] != 4) begin
      n_errors++;
      $display("FAIL duty4_timeout got %0d exp 4", m_duty[0][0]);
    end
    lit = 0; ticks = 0;
    for (int j = 0; j < PER; j++) begin
      tick();
      if (leds1[0] === 1'b0) lit++;
      if (tick1 === 1'b1) ticks++;
      n_checks++;
      if (leds1 !== {3'b111, (j < 4) ? 1'b0 : 1'b1}) begin
        n_errors++;
        $display("FAIL duty4_shape j=%0d got %b exp led0=%0d", j, leds1, (j < 4) ? 0 : 1);
      end
    end
    n_checks++;
    if (lit != 4 || ticks != 1) begin
      n_errors++;
      $display("FAIL duty4_count got lit=%0d ticks=%0d exp 4/1", lit, ticks);
    end
  endtask

  task automatic test_reversal();
    int   lit;
    logic busy_last, busy_after;
    do_reset(4'b0001);
    for (int k = 0; k < 400 && m_duty[0][0] != 10; k++) tick();
    pattern = 4'b0000;
    busy_last = 1'bx; busy_after = 1'bx;
    for (int k = 0; k <= 10; k++) begin
      lit = 0;
      for (int j = 0; j < PER; j++) begin
        tick();
        if (leds1[0] === 1'b0) lit++;
        if (k == 9 && j == PER - 1) busy_last = busy1;
        if (k == 10 && j == 0) busy_after = busy1;
      end
      n_checks++;
      if (lit != 10 - k) begin
        n_errors++;
        $display("FAIL reversal_duty period=%0d got %0d exp %0d", k, lit, 10 - k);
      end
    end
    n_checks++;
    if ({busy_last, busy_after} !== 2'b10) begin
      n_errors++;
      $display("FAIL reversal_busy got %b%b exp 10", busy_last, busy_after);
    end
  endtask

  task automatic test_enable();
    int lit;
    do_reset(4'b0001);
    for (int k = 0; k < 400 && m_duty[0][0] != 6; k++) tick();
    enable = 1'b0;
    repeat (3 * PER) begin
      tick();
      n_checks++;
      if (leds1 !== 4'b1111) begin
        n_errors++;
        $display("FAIL disabled_dark t=%0d got %b exp 1111", m_t, leds1);
      end
    end
    enable = 1'b1;
    lit = 0;
    repeat (PER) begin
      tick();
      if (leds1[0] === 1'b0) lit++;
    end
    n_checks++;
    if (lit != 9) begin
      n_errors++;
      $display("FAIL reenable_duty got %0d exp 9", lit);
    end
  endtask

  task automatic test_fade_div3();
    int lit, ticks;
    do_reset(4'b0001);
    for (int p = 0; p < 9; p++) begin
      lit = 0; ticks = 0;
      repeat (PER) begin
        tick();
        if (leds3[0] === 1'b0) lit++;
        if (tick3 === 1'b1) ticks++;
      end
      n_checks++;
      if (lit != p / 3 || ticks != 1) begin
        n_errors++;
        $display("FAIL div3_period p=%0d got lit=%0d ticks=%0d exp %0d/1", p, lit, ticks, p / 3);
      end
    end
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({leds1, leds3, busy1, busy3} !== 10'b1111_1111_0_0) begin
      n_errors++;
      $display("FAIL midfade_reset got %b %b %b %b exp 1111 1111 0 0", leds1, leds3, busy1, busy3);
    end
    rst_n = 1'b1;
    lit = 0;
    repeat (PER) begin
      tick();
      if (leds3[0] === 1'b0 || leds1[0] === 1'b0) lit++;
    end
    n_checks++;
    if (lit != 0) begin
      n_errors++;
      $display("FAIL post_reset_duty got %0d lit exp 0", lit);
    end
  endtask

  task automatic test_random();
    do_reset(4'($urandom));
    repeat (3000) begin
      if ($urandom_range(149) == 0) pattern = 4'($urandom);
      if ($urandom_range(99) == 0)  enable = ~enable;
      rst_n = ($urandom_range(799) != 0);
      tick();
      n_checks++;
      if ({leds1, busy1, tick1} !== {e_leds[0], e_busy[0], e_tick}) begin
        n_errors++;
        $display("FAIL rand_div1 t=%0d got %b%b%b exp %b%b%b", m_t, leds1, busy1, tick1, e_leds[0], e_busy[0], e_tick);
      end
      n_checks++;
      if ({leds3, busy3, tick3} !== {e_leds[1], e_busy[1], e_tick}) begin
        n_errors++;
        $display("FAIL rand_div3 t=%0d got %b%b%b exp %b%b%b", m_t, leds3, busy3, tick3, e_leds[1], e_busy[1], e_tick);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; pattern = '0;
    test_reset();
    test_ramp_up();
    test_pwm_duty4();
    test_reversal();
    test_enable();
    test_fade_div3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
- Downstream stage of the blink counter. It consumes the per-LED on/off pattern and drives the board's active-low LEDs.
- Instead of switching each LED hard, it ramps the LED's PWM duty up or down one step at a time, so pattern changes appear as smooth fades.
- Sits between the pattern source and the top-level LED pins. One instance per board top.

Parameters:
- CLK_FREQ_HZ, 10000000, system clock frequency. Documentation only; no logic depends on it.
- N_LEDS, 8, number of LED channels. The top passes the board's LED count.
- PWM_BITS, 8, PWM counter and duty width. PWM period = 2^PWM_BITS cycles. Legal range 2..12.
- FADE_DIV, 100, number of PWM periods per duty step. Must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pattern_i  in  N_LEDS  target state per LED, active-high (1 = LED should be on)
- enable_i  in  1  1 = normal operation; 0 = LEDs forced dark
- leds  out  N_LEDS  LED pins, active-low (0 = lit)
- busy_o  out  1  1 while any channel's duty is not at its target extreme
- period_tick_o  out  1  one-cycle pulse on the last cycle of each PWM period

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; all state is updated only on the rising edge of clk.
- Reset values:
  - pwm_cnt = 0, fade_cnt = 0, all duty[i] = 0.
  - leds = all 1s (dark), busy_o = 0, period_tick_o = 0.
  - Reset asserted mid-fade discards duty immediately; leds read all 1s on the cycle after the reset edge.
- Constant: MAX = 2^PWM_BITS - 1.
- pwm_cnt:
  - Free-running 0..MAX, increments every cycle, wraps MAX -> 0.
  - Runs regardless of enable_i.
- period_tick_o:
  - Registered; equals 1 in the cycle after pwm_cnt == MAX, i.e. aligned with pwm_cnt == 0.
  - Exactly one cycle wide.
- fade_cnt:
  - Counts 0..FADE_DIV-1 and advances when pwm_cnt == MAX.
  - A step is due when pwm_cnt == MAX and fade_cnt == FADE_DIV-1; fade_cnt wraps to 0 on that cycle.
  - With FADE_DIV = 1, a step is due every period.
- Step rule, applied per channel on a due cycle, using pattern_i sampled on that cycle:
  - pattern_i[i] = 1 and duty < MAX: duty + 1.
  - pattern_i[i] = 0 and duty > 0: duty - 1.
  - Otherwise duty holds; it saturates at both ends and never wraps.
  - pattern_i changes between steps are ignored.
  - A reversal mid-fade takes effect at the next step, from the current duty. No restart.
- Compare:
  - on[i] = (duty[i] == MAX) or (pwm_cnt < duty[i]).
  - duty = 0 gives always dark; duty = MAX gives always lit, with no one-cycle glitch.
  - leds[i] = ~(on[i] & enable_i), registered, so there is one cycle of latency from pwm_cnt/duty to the pin.
- enable_i = 0:
  - leds go all 1s on the next cycle.
  - duty continues to step normally, so on re-enable the LEDs show the current duty with no jump back.
- busy_o (registered):
  - 1 iff some channel has pattern_i = 1 with duty < MAX, or pattern_i = 0 with duty > 0.
  - Evaluated every cycle.
- Full fade time = MAX * FADE_DIV * 2^PWM_BITS cycles. Defaults: 6,528,000 cycles, about 0.65 s at 10 MHz.
- Widths:
  - fade_cnt is $clog2(FADE_DIV) bits, minimum 1.
  - All compares are unsigned, at PWM_BITS width.

Decomposition:
- Package led_pkg: the derived PWM_MAX function/constant and a FADE_CNT_W helper. No typedefs needed beyond these.
- Sub-module led_pwm_channel, instantiated N_LEDS times via generate. It holds:
  - one duty register;
  - the saturating step logic;
  - the compare and the output flop.
- Shared logic stays in the parent: pwm_cnt, fade_cnt, step-due strobe, period_tick_o, and the OR-reduction of per-channel busy bits.

Test Plan (PWM_BITS=4, FADE_DIV=1, N_LEDS=4 unless stated):
- Reset with pattern_i=4'b1111 -> leds=4'b1111 and busy_o=0 held during reset. busy_o=1 one cycle after release.
- pattern_i=4'b0001 after reset -> duty[0] reaches 15 after 15 steps (15*16 cycles). Then leds[0]=0 every cycle, busy_o=0, and leds[3:1] stay 1.
- Freeze at duty[0]=4 -> per 16-cycle period, leds[0]=0 for exactly 4 cycles (pwm_cnt 0..3, seen one cycle late) and 1 for 12. period_tick_o fires once per 16 cycles.
- At duty[0]=10, drop pattern_i[0] -> next step gives duty 9, then monotonic descent to 0 with no jump. busy_o falls the cycle after duty reaches 0.
- enable_i=0 mid-fade -> leds=4'b1111 next cycle while duty keeps stepping. Re-enable: the duty visible on leds matches the step count.
- FADE_DIV=3 -> a duty step occurs only every 3rd period_tick_o. Asserting rst_n=0 mid-fade returns all duty to 0 and leds to 4'b1111 on the next cycle.
